// File: rtl/encoder_tx_pkg.sv
// Shared definitions for the encoder frame scheduler: FSM state encoding,
// frame geometry, default header byte and the frame byte selector.
package encoder_tx_pkg;

  localparam int unsigned FRAME_LEN      = 4;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned WAIT_W         = 2;
  localparam int unsigned BUSY_TIMEOUT   = 3;
  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_e;

  // Values captured at LOAD and carried through the whole frame.
  typedef struct packed {
    logic [7:0] count;
    logic       chg;
    logic       button;
  } snap_t;

  // Byte idx of a frame: header, count, flags, additive checksum.
  function automatic logic [7:0] frame_byte(input logic [7:0]       hdr,
                                            input snap_t            snap,
                                            input logic [IDX_W-1:0] idx);
    logic [7:0] flags;
    flags = {6'b0, snap.chg, snap.button};
    case (idx)
      2'd0:    frame_byte = hdr;
      2'd1:    frame_byte = snap.count;
      2'd2:    frame_byte = flags;
      default: frame_byte = 8'(hdr + snap.count + flags);
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Periodic tick generator.
// Ports: i_clk, i_reset (sync, active-high), o_tick (one-cycle pulse each
// time the free-running 0..PERIOD-1 counter wraps to 0).
module tick_gen #(
  parameter int unsigned PERIOD = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Free-running counter; tick is registered so it lines up with the wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_W'(PERIOD - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/encoder_tx_sched.sv
// Encoder report scheduler: builds 4-byte frames (header, count, flags,
// checksum) and feeds them byte by byte to a UART transmitter.
// Frames are triggered by a periodic tick, a manual request rising edge and,
// when ENC_TX_ON_CHANGE_EN is defined, by the count differing from the last
// reported value. Triggers coalesce into a single pending frame.
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   count_i         live encoder count
//   button_i        push-button level
//   send_req        manual request level (rising edge triggers)
//   tx_busy         transmitter busy flag
//   tx_start        one-cycle byte start strobe (decoded from state/tx_busy)
//   tx_data         byte to send, valid with tx_start
//   frame_active    high from LOAD until the last byte completes
//   frames_sent     completed frame counter (wraps)
// Configuration macro: ENC_TX_ON_CHANGE_EN (on-change reporting).
// PERIOD = CLK_HZ/REPORT_HZ must be at least 8.
module encoder_tx_sched
  import encoder_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned REPORT_HZ = 20,
  parameter logic [7:0]  HEADER    = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count_i,
  input  logic       button_i,
  input  logic       send_req,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_active,
  output logic [7:0] frames_sent
);

  localparam int unsigned PERIOD   = CLK_HZ / REPORT_HZ;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(BUSY_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_tx_start;
  logic              w_tick;
  logic              w_req_rise;
  logic              w_change;
  logic              w_trigger;

  logic              r_req_d;
  logic              r_pending;
  snap_t             r_snap;
  logic [IDX_W-1:0]  r_idx;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [7:0]        r_last_count;
  logic              r_sent_any;
  logic [7:0]        r_frames_sent;
  logic              r_frame_active;
  logic [7:0]        r_tx_data;

  tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_tick)
  );

  assign w_req_rise = send_req & ~r_req_d;

`ifdef ENC_TX_ON_CHANGE_EN
  // Report a moved count only while no frame is being built or sent.
  assign w_change = (count_i != r_last_count) & ~r_frame_active;
`else
  assign w_change = 1'b0;
`endif

  assign w_trigger = w_tick | w_req_rise | w_change;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (r_pending) w_next_state = ST_LOAD;
      ST_LOAD:    w_next_state = ST_START;
      ST_START:   if (!tx_busy) w_next_state = ST_WAIT_HI;
      // A transmitter that never shows busy is treated as having taken the byte.
      ST_WAIT_HI: if (tx_busy || (r_wait_cnt == WAIT_MAX)) w_next_state = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          w_next_state = (r_idx == LAST_IDX) ? ST_IDLE : ST_START;
        end
      end
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: the strobe fires in the START cycle the transmitter is free.
  always_comb begin
    w_tx_start = 1'b0;
    if ((r_state == ST_START) && !tx_busy) begin
      w_tx_start = 1'b1;
    end
  end

  // Trigger capture, frame snapshot, byte sequencing and completion bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_d        <= 1'b0;
      r_pending      <= 1'b0;
      r_snap         <= '0;
      r_idx          <= '0;
      r_wait_cnt     <= '0;
      r_last_count   <= '0;
      r_sent_any     <= 1'b0;
      r_frames_sent  <= '0;
      r_frame_active <= 1'b0;
      r_tx_data      <= '0;
    end else begin
      r_req_d        <= send_req;
      r_frame_active <= (w_next_state != ST_IDLE);

      // A trigger in the LOAD cycle wins over the clear and yields another frame.
      if (w_trigger) begin
        r_pending <= 1'b1;
      end else if (r_state == ST_LOAD) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        ST_LOAD: begin
          r_snap.count  <= count_i;
          r_snap.button <= button_i;
          r_snap.chg    <= r_sent_any & (count_i != r_last_count);
          r_idx         <= '0;
          r_tx_data     <= HEADER;
        end
        ST_START: begin
          r_wait_cnt <= '0;
        end
        ST_WAIT_HI: begin
          if (!tx_busy) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (r_idx != LAST_IDX) begin
              r_idx     <= r_idx + 1'b1;
              r_tx_data <= frame_byte(HEADER, r_snap, IDX_W'(r_idx + 1'b1));
            end else begin
              r_frames_sent <= r_frames_sent + 1'b1;
              r_last_count  <= r_snap.count;
              r_sent_any    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_start     = w_tx_start;
  assign tx_data      = r_tx_data;
  assign frame_active = r_frame_active;
  assign frames_sent  = r_frames_sent;

endmodule

// File: tb/tb_encoder_tx_sched.sv
// Directed bench for encoder_tx_sched with a UART busy model and a byte
// scoreboard (expected bytes queued at trigger time, popped on tx_start).
module tb_encoder_tx_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count_i;
  logic       button_i;
  logic       send_req;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_active;
  logic [7:0] frames_sent;

  logic       model_en;
  logic       force_busy;
  logic       model_busy = 1'b0;
  int         busy_left  = 0;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         n_starts = 0;
  int         last_start_cyc = 0;
  logic [7:0] exp_q[$];

  encoder_tx_sched #(
    .CLK_HZ    (1000),
    .REPORT_HZ (10),
    .HEADER    (8'hA5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .count_i      (count_i),
    .button_i     (button_i),
    .send_req     (send_req),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .frame_active (frame_active),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: busy rises the cycle after tx_start and stays up 10 cycles.
  always @(posedge clk) begin
    if (model_en && tx_start) begin
      busy_left  <= 10;
      model_busy <= 1'b1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) model_busy <= 1'b0;
    end
  end

  assign tx_busy = model_busy | force_busy;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [7:0] c, input logic b, input logic chg);
    logic [7:0] f;
    f = {6'b0, chg, b};
    exp_q.push_back(8'hA5);
    exp_q.push_back(c);
    exp_q.push_back(f);
    exp_q.push_back(8'(8'hA5 + c + f));
  endtask

  // Sample at the falling edge, return just after the next rising edge.
  task automatic step(input int n);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        n_starts++;
        last_start_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte cyc %0d got %02h required none", cyc, tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_byte cyc %0d got %02h required %02h", cyc, tx_data, exp_b);
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_starts < target && k < budget) begin
      step(1);
      k++;
    end
    if (n_starts < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout starts %0d required %0d", tag, n_starts, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (frame_active !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    if (frame_active !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s idle_timeout frame_active %b required 0", tag, frame_active);
    end
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
  endtask

  task automatic do_reset(output int rel_cyc);
    reset    = 1'b1;
    send_req = 1'b0;
    step(2);
    exp_q.delete();
    n_starts = 0;
    reset    = 1'b0;
    rel_cyc  = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b required 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %02h required 00", tx_data); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got %b required 0", frame_active); end
    checks++; if (frames_sent !== 8'h00) begin errors++; $display("FAIL reset_frames_sent got %0d required 0", frames_sent); end
  endtask

  task automatic test_periodic();
    int r;
    int t1;
    count_i  = 8'h12;
    button_i = 1'b1;
    do_reset(r);
    push_frame(8'h12, 1'b1, 1'b0);
    wait_starts(1, 150, "periodic_first");
    t1 = last_start_cyc;
    checks++; if (t1 != r + 103) begin errors++; $display("FAIL periodic_latency got %0d required %0d", t1 - r, 103); end
    wait_starts(4, 60, "periodic_bytes");
    wait_idle(20, "periodic");
    checks++; if (frames_sent !== 8'd1) begin errors++; $display("FAIL periodic_frames_sent got %0d required 1", frames_sent); end
    push_frame(8'h12, 1'b1, 1'b0);
    wait_starts(5, 200, "periodic_second");
    checks++; if (last_start_cyc - t1 != 100) begin errors++; $display("FAIL periodic_spacing got %0d required 100", last_start_cyc - t1); end
    wait_starts(6, 20, "periodic_second_b1");
  endtask

  task automatic test_manual();
    int r;
    int trig;
    count_i  = 8'h3C;
    button_i = 1'b0;
    do_reset(r);
    step(5);
    send_req = 1'b1;
    trig = cyc;
    push_frame(8'h3C, 1'b0, 1'b0);
    wait_starts(1, 20, "manual_first");
    checks++; if (last_start_cyc != trig + 3) begin errors++; $display("FAIL manual_latency got %0d required 3", last_start_cyc - trig); end
    wait_starts(4, 60, "manual_bytes");
    wait_idle(20, "manual");
    step(20);
    checks++; if (n_starts != 4) begin errors++; $display("FAIL manual_held_starts got %0d required 4", n_starts); end
    checks++; if (frames_sent !== 8'd1) begin errors++; $display("FAIL manual_frames_sent got %0d required 1", frames_sent); end
    send_req = 1'b0;
  endtask

  task automatic test_coalesce();
    int r;
    count_i  = 8'h40;
    button_i = 1'b1;
    do_reset(r);
    step(2);
    pulse_req();
    push_frame(8'h40, 1'b1, 1'b0);
    wait_starts(1, 20, "coalesce_first");
    count_i = 8'h41;
    push_frame(8'h41, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8);
      pulse_req();
    end
    wait_starts(8, 150, "coalesce_bytes");
    wait_idle(20, "coalesce");
    checks++; if (frames_sent !== 8'd2) begin errors++; $display("FAIL coalesce_frames_sent got %0d required 2", frames_sent); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL coalesce_leftover got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_busy_hold();
    int r;
    int f;
    count_i    = 8'h55;
    button_i   = 1'b0;
    do_reset(r);
    force_busy = 1'b1;
    step(1);
    pulse_req();
    push_frame(8'h55, 1'b0, 1'b0);
    step(50);
    checks++; if (n_starts != 0) begin errors++; $display("FAIL busy_hold_starts got %0d required 0", n_starts); end
    force_busy = 1'b0;
    f = cyc;
    wait_starts(1, 5, "busy_release");
    checks++; if (last_start_cyc != f) begin errors++; $display("FAIL busy_release_cyc got %0d required %0d", last_start_cyc, f); end
    wait_starts(4, 60, "busy_bytes");
    wait_idle(20, "busy");
    checks++; if (frames_sent !== 8'd1) begin errors++; $display("FAIL busy_frames_sent got %0d required 1", frames_sent); end
  endtask

  task automatic test_busy_timeout();
    int r;
    int prev;
    model_en = 1'b0;
    count_i  = 8'h7F;
    button_i = 1'b1;
    do_reset(r);
    pulse_req();
    push_frame(8'h7F, 1'b1, 1'b0);
    wait_starts(1, 20, "timeout_first");
    for (int i = 2; i <= 4; i++) begin
      prev = last_start_cyc;
      wait_starts(i, 20, "timeout_next");
      checks++; if (last_start_cyc - prev != 5) begin errors++; $display("FAIL timeout_spacing byte %0d got %0d required 5", i, last_start_cyc - prev); end
    end
    wait_idle(20, "timeout");
    checks++; if (frames_sent !== 8'd1) begin errors++; $display("FAIL timeout_frames_sent got %0d required 1", frames_sent); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int r;
    int base;
    count_i  = 8'h12;
    button_i = 1'b1;
    do_reset(r);
    pulse_req();
    push_frame(8'h12, 1'b1, 1'b0);
    wait_starts(2, 40, "midframe_second");
    step(3);
    reset = 1'b1;
    step(2);
    exp_q.delete();
    checks++; if (frames_sent !== 8'd0) begin errors++; $display("FAIL midframe_frames_sent got %0d required 0", frames_sent); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL midframe_frame_active got %b required 0", frame_active); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midframe_tx_data got %02h required 00", tx_data); end
    base  = n_starts;
    reset = 1'b0;
    step(60);
    checks++; if (n_starts != base) begin errors++; $display("FAIL midframe_extra_starts got %0d required %0d", n_starts, base); end
  endtask

`ifdef ENC_TX_ON_CHANGE_EN
  task automatic test_on_change();
    int r;
    count_i  = 8'h00;
    button_i = 1'b1;
    do_reset(r);
    step(5);
    checks++; if (n_starts != 0) begin errors++; $display("FAIL change_quiet_starts got %0d required 0", n_starts); end
    count_i = 8'h12;
    push_frame(8'h12, 1'b1, 1'b0);
    wait_starts(4, 60, "change_first");
    wait_idle(20, "change_first");
    count_i = 8'h13;
    push_frame(8'h13, 1'b1, 1'b1);
    wait_starts(8, 60, "change_second");
    wait_idle(20, "change_second");
    checks++; if (frames_sent !== 8'd2) begin errors++; $display("FAIL change_frames_sent got %0d required 2", frames_sent); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    count_i    = 8'h00;
    button_i   = 1'b0;
    send_req   = 1'b0;
    force_busy = 1'b0;
    model_en   = 1'b1;
    test_reset();
`ifdef ENC_TX_ON_CHANGE_EN
    test_on_change();
`else
    test_periodic();
    test_manual();
    test_coalesce();
    test_busy_hold();
    test_busy_timeout();
    test_reset_mid_frame();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
